// File: rtl/gpio_in_pkg.sv
// Shared definitions for the GPIO input port: bus width, default base address,
// register offsets and the register-select encoding.
package gpio_in_pkg;

  localparam int MXLEN = 32;

  localparam logic [MXLEN-1:0] GPIO_IN_BASE = 32'h0000_1100;

  // Byte offsets of the four registers relative to the base address.
  localparam logic [MXLEN-1:0] GPIO_IN_DATA = 32'h0000_0000;
  localparam logic [MXLEN-1:0] GPIO_IN_RISE = 32'h0000_0004;
  localparam logic [MXLEN-1:0] GPIO_IN_FALL = 32'h0000_0008;
  localparam logic [MXLEN-1:0] GPIO_IN_IE   = 32'h0000_000C;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RISE = 2'd1,
    REG_FALL = 2'd2,
    REG_IE   = 2'd3
  } reg_sel_e;

  // Word index within the 16-byte register window -> register select.
  function automatic reg_sel_e word_sel(input logic [1:0] word);
    return reg_sel_e'(word);
  endfunction

endpackage

// File: rtl/gpio_in_if.sv
// Data-bus slice seen by the GPIO input port: address, load/store strobes,
// store data, combinational read data and the registered interrupt request.
interface gpio_in_if;

  logic [gpio_in_pkg::MXLEN-1:0] addr;
  logic                          load;
  logic                          store;
  logic [gpio_in_pkg::MXLEN-1:0] w_data;
  logic [gpio_in_pkg::MXLEN-1:0] r_data;
  logic                          irq;

  modport master (
    output addr,
    output load,
    output store,
    output w_data,
    input  r_data,
    input  irq
  );

  modport slave (
    input  addr,
    input  load,
    input  store,
    input  w_data,
    output r_data,
    output irq
  );

endinterface

// File: rtl/gpio_in_filter.sv
// One pin's front end: two-flop synchroniser, debounce counter and debounced level,
// plus single-cycle pulses on the edge where the debounced level changes.
module gpio_in_filter #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int              CW   = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          stable_reg;
  logic          stable_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Any cycle where the synchronised input agrees with the stable level
  // restarts the window, so the counter never exceeds LAST.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    accept      = 1'b0;
    if (s2_reg != stable_reg) begin
      if (cnt_reg == LAST) begin
        accept      = 1'b1;
        stable_next = s2_reg;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      s1_reg     <= pin;
      s2_reg     <= s1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Edge pulses are asserted in the cycle before stable flips so the top can
  // set its pending bits on the same edge that updates the level.
  assign stable = stable_reg;
  assign rise   = accept &  s2_reg;
  assign fall   = accept & ~s2_reg;

endmodule

// File: rtl/gpio_in.sv
// Memory-mapped GPIO input port: per-pin debounced levels, sticky W1C rise/fall
// pending bits, per-pin interrupt enable and a registered level interrupt.
module gpio_in
  import gpio_in_pkg::*;
#(
  parameter int               NPINS    = 4,
  parameter int               DEBOUNCE = 16,
  parameter logic [MXLEN-1:0] BASE     = GPIO_IN_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPINS-1:0] pins,
  gpio_in_if.slave         bus
);

  logic [NPINS-1:0] stable;
  logic [NPINS-1:0] rise_evt;
  logic [NPINS-1:0] fall_evt;

  generate
    for (genvar gi = 0; gi < NPINS; gi++) begin : g_pin
      gpio_in_filter #(
        .DEBOUNCE(DEBOUNCE)
      ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (pins[gi]),
        .stable (stable[gi]),
        .rise   (rise_evt[gi]),
        .fall   (fall_evt[gi])
      );
    end
  endgenerate

  logic             hit;
  reg_sel_e         sel;
  logic [NPINS-1:0] wmask;
  logic             wr_rise;
  logic             wr_fall;
  logic             wr_ie;

  logic [NPINS-1:0] rise_reg;
  logic [NPINS-1:0] rise_next;
  logic [NPINS-1:0] fall_reg;
  logic [NPINS-1:0] fall_next;
  logic [NPINS-1:0] ie_reg;
  logic [NPINS-1:0] ie_next;
  logic             irq_reg;
  logic             irq_next;
  logic [NPINS-1:0] rd_val;

  // Only the 16-byte window is decoded; the byte offset within a word is ignored.
  assign hit   = (bus.addr[MXLEN-1:4] == BASE[MXLEN-1:4]);
  assign sel   = word_sel(bus.addr[3:2]);
  assign wmask = bus.w_data[NPINS-1:0];

  always_comb begin
    wr_rise = 1'b0;
    wr_fall = 1'b0;
    wr_ie   = 1'b0;
    if (bus.store && hit) begin
      wr_rise = (sel == REG_RISE);
      wr_fall = (sel == REG_FALL);
      wr_ie   = (sel == REG_IE);
    end
  end

  // A new edge on the same cycle as a W1C keeps its pending bit set.
  always_comb begin
    rise_next = rise_reg;
    fall_next = fall_reg;
    ie_next   = ie_reg;
    if (wr_rise) begin
      rise_next = rise_reg & ~wmask;
    end
    if (wr_fall) begin
      fall_next = fall_reg & ~wmask;
    end
    if (wr_ie) begin
      ie_next = wmask;
    end
    rise_next = rise_next | rise_evt;
    fall_next = fall_next | fall_evt;
    irq_next  = |((rise_reg | fall_reg) & ie_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_reg <= '0;
      fall_reg <= '0;
      ie_reg   <= '0;
      irq_reg  <= 1'b0;
    end else begin
      rise_reg <= rise_next;
      fall_reg <= fall_next;
      ie_reg   <= ie_next;
      irq_reg  <= irq_next;
    end
  end

  // Read path is purely combinational and side-effect free, so a simultaneous
  // store is observed with its pre-store contents.
  always_comb begin
    rd_val = '0;
    unique case (sel)
      REG_DATA: rd_val = stable;
      REG_RISE: rd_val = rise_reg;
      REG_FALL: rd_val = fall_reg;
      REG_IE:   rd_val = ie_reg;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    bus.r_data = '0;
    if (bus.load && hit) begin
      bus.r_data[NPINS-1:0] = rd_val;
    end
  end

  assign bus.irq = irq_reg;

  logic unused_bus_bits;
  generate
    if (NPINS < MXLEN) begin : g_unused_wide
      assign unused_bus_bits = ^{bus.addr[1:0], bus.w_data[MXLEN-1:NPINS]};
    end else begin : g_unused_full
      assign unused_bus_bits = ^bus.addr[1:0];
    end
  endgenerate

endmodule
